// File: rtl/world_clock_multi.sv
// world_clock_multi: base UTC H:M:S counter with prescaler, time-set and pause,
// plus NUM_ZONES registered zone clocks derived from signed minute offsets.
module world_clock_multi #(
  parameter int NUM_ZONES     = 4,
  parameter int TICKS_PER_SEC = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   set_en,
  input  logic [4:0]             set_hours,
  input  logic [5:0]             set_mins,
  input  logic [5:0]             set_secs,
  input  logic                   mode12,
  input  logic [NUM_ZONES*11-1:0] zone_offset,
  output logic                   cycle,
  output logic [6:0]             hours,
  output logic [6:0]             minutes,
  output logic [6:0]             seconds,
  output logic [NUM_ZONES*7-1:0] zone_hours,
  output logic [NUM_ZONES*7-1:0] zone_minutes,
  output logic [NUM_ZONES-1:0]   zone_pm,
  output logic [NUM_ZONES*2-1:0] zone_day
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] pcount_q, pcount_d;
  logic [4:0]    hours_q, hours_d;
  logic [5:0]    mins_q, mins_d;
  logic [5:0]    secs_q, secs_d;
  logic          cycle_q, cycle_d;
  logic          set_ok;
  logic          tick;

  // Next-state for prescaler and base time: a valid set beats a tick, else hold.
  always_comb begin
    set_ok   = set_en && (set_hours <= 5'd23) && (set_mins <= 6'd59) && (set_secs <= 6'd59);
    tick     = en && (pcount_q == PMAX);
    pcount_d = pcount_q;
    hours_d  = hours_q;
    mins_d   = mins_q;
    secs_d   = secs_q;
    cycle_d  = 1'b0;
    if (set_ok) begin
      hours_d  = set_hours;
      mins_d   = set_mins;
      secs_d   = set_secs;
      pcount_d = '0;
    end else if (tick) begin
      pcount_d = '0;
      if (secs_q == 6'd59) begin
        secs_d = 6'd0;
        if (mins_q == 6'd59) begin
          mins_d = 6'd0;
          if (hours_q == 5'd23) begin
            hours_d = 5'd0;
            cycle_d = 1'b1;
          end else begin
            hours_d = hours_q + 5'd1;
          end
        end else begin
          mins_d = mins_q + 6'd1;
        end
      end else begin
        secs_d = secs_q + 6'd1;
      end
    end else if (en) begin
      pcount_d = pcount_q + 1'b1;
    end
  end

  // Base state registers; cycle is high alongside the 00:00:00 it announces.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pcount_q <= '0;
      hours_q  <= '0;
      mins_q   <= '0;
      secs_q   <= '0;
      cycle_q  <= 1'b0;
    end else begin
      pcount_q <= pcount_d;
      hours_q  <= hours_d;
      mins_q   <= mins_d;
      secs_q   <= secs_d;
      cycle_q  <= cycle_d;
    end
  end

  assign cycle   = cycle_q;
  assign hours   = {2'b00, hours_q};
  assign minutes = {1'b0, mins_q};
  assign seconds = {1'b0, secs_q};

  // Minute-of-day of the base time, shared by every zone.
  logic [12:0] base_m;
  assign base_m = 13'(hours_q) * 13'd60 + 13'(mins_q);

  for (genvar gi = 0; gi < NUM_ZONES; gi++) begin : g_zone
    logic signed [10:0] off_raw;
    logic signed [12:0] off_c;
    logic signed [12:0] m_sum;
    logic signed [12:0] m_wrap;
    logic [10:0]        m_u;
    logic [4:0]         h24;
    logic [5:0]         mm;
    logic [1:0]         day_d;
    logic [6:0]         zh_d;
    logic               pm_d;
    logic [6:0]         zh_q, zm_q;
    logic               pm_q;
    logic [1:0]         day_q;

    // Clamp offset, wrap the local minute-of-day into 0..1439 and format hours.
    always_comb begin
      off_raw = zone_offset[11*gi +: 11];
      off_c   = {{2{off_raw[10]}}, off_raw};
      if (off_c < -13'sd720)     off_c = -13'sd720;
      else if (off_c > 13'sd840) off_c = 13'sd840;
      m_sum = $signed(base_m) + off_c;
      if (m_sum < 13'sd0) begin
        m_wrap = m_sum + 13'sd1440;
        day_d  = 2'b11;
      end else if (m_sum >= 13'sd1440) begin
        m_wrap = m_sum - 13'sd1440;
        day_d  = 2'b01;
      end else begin
        m_wrap = m_sum;
        day_d  = 2'b00;
      end
      m_u = m_wrap[10:0];
      h24 = 5'(m_u / 11'd60);
      mm  = 6'(m_u % 11'd60);
      if (mode12) begin
        pm_d = (h24 >= 5'd12);
        zh_d = {2'b00, (h24 >= 5'd12) ? (h24 - 5'd12) : h24};
        if (zh_d == 7'd0) zh_d = 7'd12;
      end else begin
        pm_d = 1'b0;
        zh_d = {2'b00, h24};
      end
    end

    // Zone outputs recompute every cycle from the base registers.
    always_ff @(posedge clk) begin
      if (!reset) begin
        zh_q  <= '0;
        zm_q  <= '0;
        pm_q  <= 1'b0;
        day_q <= '0;
      end else begin
        zh_q  <= zh_d;
        zm_q  <= {1'b0, mm};
        pm_q  <= pm_d;
        day_q <= day_d;
      end
    end

    assign zone_hours[7*gi +: 7]   = zh_q;
    assign zone_minutes[7*gi +: 7] = zm_q;
    assign zone_pm[gi]             = pm_q;
    assign zone_day[2*gi +: 2]     = day_q;
  end

endmodule

// File: tb/tb_world_clock_multi.sv
// Bench for world_clock_multi: directed stimulus pushes expected values tagged
// with the clock edge they belong to; a negedge monitor pops and compares.
module tb_world_clock_multi;
  localparam int NZ = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, en, set_en, mode12;
  logic [4:0]     set_hours;
  logic [5:0]     set_mins, set_secs;
  logic [NZ*11-1:0] zone_offset;
  logic           cycle;
  logic [6:0]     hours, minutes, seconds;
  logic [NZ*7-1:0] zone_hours, zone_minutes;
  logic [NZ-1:0]  zone_pm;
  logic [NZ*2-1:0] zone_day;

  // Second instance with a 4-cycle prescaler and one zone.
  logic           en4, set_en4, mode12_4;
  logic [4:0]     set_hours4;
  logic [5:0]     set_mins4, set_secs4;
  logic [10:0]    zone_offset4;
  logic           cycle4;
  logic [6:0]     hours4, minutes4, seconds4;
  logic [6:0]     zone_hours4, zone_minutes4;
  logic [0:0]     zone_pm4;
  logic [1:0]     zone_day4;

  world_clock_multi #(.NUM_ZONES(NZ), .TICKS_PER_SEC(1)) dut (
    .clk(clk), .reset(reset), .en(en), .set_en(set_en),
    .set_hours(set_hours), .set_mins(set_mins), .set_secs(set_secs),
    .mode12(mode12), .zone_offset(zone_offset),
    .cycle(cycle), .hours(hours), .minutes(minutes), .seconds(seconds),
    .zone_hours(zone_hours), .zone_minutes(zone_minutes),
    .zone_pm(zone_pm), .zone_day(zone_day)
  );

  world_clock_multi #(.NUM_ZONES(1), .TICKS_PER_SEC(4)) dut4 (
    .clk(clk), .reset(reset), .en(en4), .set_en(set_en4),
    .set_hours(set_hours4), .set_mins(set_mins4), .set_secs(set_secs4),
    .mode12(mode12_4), .zone_offset(zone_offset4),
    .cycle(cycle4), .hours(hours4), .minutes(minutes4), .seconds(seconds4),
    .zone_hours(zone_hours4), .zone_minutes(zone_minutes4),
    .zone_pm(zone_pm4), .zone_day(zone_day4)
  );

  typedef struct {
    int cyc;
    int kind;
    int zone;
    int val;
  } exp_t;

  exp_t sb[$];
  int   edges = 0;
  int   total = 0;
  int   bad   = 0;
  string knames[9] = '{"hours", "minutes", "seconds", "cycle", "zone_hours",
                       "zone_minutes", "zone_pm", "zone_day", "seconds_tps4"};

  always @(posedge clk) edges++;

  // Expected value for the DUT state seen after edge (edges + k); kept in edge order.
  task automatic expect_at(input int k, input int kind, input int zone, input int val);
    exp_t e;
    int   i;
    e.cyc  = edges + k;
    e.kind = kind;
    e.zone = zone;
    e.val  = val;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endtask

  function automatic int actual(input int kind, input int z);
    case (kind)
      0: return int'(hours);
      1: return int'(minutes);
      2: return int'(seconds);
      3: return int'(cycle);
      4: return int'(zone_hours[7*z +: 7]);
      5: return int'(zone_minutes[7*z +: 7]);
      6: return int'(zone_pm[z]);
      7: return int'(zone_day[2*z +: 2]);
      8: return int'(seconds4);
      default: return -1;
    endcase
  endfunction

  // Monitor: compare every expectation tagged for the current edge.
  always @(negedge clk) begin : mon
    exp_t e;
    int   a;
    while (sb.size() > 0 && sb[0].cyc <= edges) begin
      e = sb.pop_front();
      total++;
      if (e.cyc < edges) begin
        bad++;
        $display("FAIL stale %s[%0d] edge=%0d not checked in time (required %0d)",
                 knames[e.kind], e.zone, e.cyc, e.val);
      end else begin
        a = actual(e.kind, e.zone);
        if (a != e.val) begin
          bad++;
          $display("FAIL %s[%0d] edge=%0d actual=%0d required=%0d",
                   knames[e.kind], e.zone, e.cyc, a, e.val);
        end else begin
          $display("ok   %s[%0d] edge=%0d value=%0d", knames[e.kind], e.zone, e.cyc, a);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_set(input int h, input int m, input int s);
    set_en    = 1'b1;
    set_hours = 5'(h);
    set_mins  = 6'(m);
    set_secs  = 6'(s);
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; set_en = 1'b0; mode12 = 1'b0;
    set_hours = '0; set_mins = '0; set_secs = '0; zone_offset = '0;
    en4 = 1'b0; set_en4 = 1'b0; mode12_4 = 1'b0;
    set_hours4 = '0; set_mins4 = '0; set_secs4 = '0; zone_offset4 = '0;

    // T1: reset state, then seconds counts 1,2,3
    expect_at(1, 0, 0, 0); expect_at(1, 1, 0, 0); expect_at(1, 2, 0, 0); expect_at(1, 3, 0, 0);
    for (int z = 0; z < NZ; z++) begin
      expect_at(1, 4, z, 0); expect_at(1, 5, z, 0); expect_at(1, 6, z, 0); expect_at(1, 7, z, 0);
    end
    expect_at(1, 8, 0, 0);
    expect_at(2, 2, 0, 0);
    step(2);
    reset = 1'b1;
    expect_at(1, 2, 0, 1); expect_at(2, 2, 0, 2); expect_at(3, 2, 0, 3);
    step(3);

    // T2: load 23:59:58 and roll over midnight
    do_set(23, 59, 58);
    expect_at(1, 0, 0, 23); expect_at(1, 1, 0, 59); expect_at(1, 2, 0, 58); expect_at(1, 3, 0, 0);
    expect_at(2, 0, 0, 23); expect_at(2, 2, 0, 59); expect_at(2, 3, 0, 0);
    expect_at(3, 0, 0, 0);  expect_at(3, 1, 0, 0);  expect_at(3, 2, 0, 0);  expect_at(3, 3, 0, 1);
    expect_at(3, 4, 0, 23); expect_at(3, 5, 0, 59);
    expect_at(4, 3, 0, 0);  expect_at(4, 2, 0, 1);  expect_at(4, 4, 0, 0);  expect_at(4, 5, 0, 0);
    step(1);
    set_en = 1'b0;
    step(3);

    // T4: paused base 01:30:00, offsets -120, +840, +1000 (clamped), -1000 (clamped)
    en = 1'b0;
    do_set(1, 30, 0);
    zone_offset[0  +: 11] = 11'(-120);
    zone_offset[11 +: 11] = 11'd840;
    zone_offset[22 +: 11] = 11'd1000;
    zone_offset[33 +: 11] = 11'(-1000);
    expect_at(1, 0, 0, 1); expect_at(1, 1, 0, 30); expect_at(1, 2, 0, 0);
    expect_at(2, 2, 0, 0);
    expect_at(2, 4, 0, 23); expect_at(2, 5, 0, 30); expect_at(2, 7, 0, 3); expect_at(2, 6, 0, 0);
    expect_at(2, 4, 1, 15); expect_at(2, 5, 1, 30); expect_at(2, 7, 1, 0);
    expect_at(2, 4, 2, 15); expect_at(2, 5, 2, 30); expect_at(2, 7, 2, 0);
    expect_at(2, 4, 3, 13); expect_at(2, 5, 3, 30); expect_at(2, 7, 3, 3);
    step(1);
    set_en = 1'b0;
    step(1);

    // T5: 12h format at 00:15 and 13:05
    mode12 = 1'b1;
    do_set(0, 15, 0);
    zone_offset[0  +: 11] = 11'd0;
    zone_offset[11 +: 11] = 11'd60;
    zone_offset[22 +: 11] = 11'd720;
    zone_offset[33 +: 11] = 11'd0;
    expect_at(2, 4, 0, 12); expect_at(2, 5, 0, 15); expect_at(2, 6, 0, 0); expect_at(2, 7, 0, 0);
    expect_at(2, 4, 1, 1);  expect_at(2, 6, 1, 0);
    expect_at(2, 4, 2, 12); expect_at(2, 6, 2, 1);  expect_at(2, 7, 2, 0);
    step(1);
    set_en = 1'b0;
    step(1);
    do_set(13, 5, 0);
    expect_at(2, 4, 0, 1);  expect_at(2, 5, 0, 5);  expect_at(2, 6, 0, 1); expect_at(2, 7, 0, 0);
    expect_at(2, 4, 1, 2);  expect_at(2, 6, 1, 1);
    expect_at(2, 4, 2, 1);  expect_at(2, 5, 2, 5);  expect_at(2, 6, 2, 0); expect_at(2, 7, 2, 1);
    step(1);
    set_en = 1'b0;
    step(1);

    // T6: invalid set ignored (tick applies); set with reset at the same edge -> reset wins
    en = 1'b1;
    do_set(5, 60, 0);
    expect_at(1, 0, 0, 13); expect_at(1, 1, 0, 5); expect_at(1, 2, 0, 1);
    step(1);
    do_set(5, 5, 5);
    reset = 1'b0;
    expect_at(1, 0, 0, 0); expect_at(1, 1, 0, 0); expect_at(1, 2, 0, 0); expect_at(1, 3, 0, 0);
    expect_at(1, 4, 0, 0); expect_at(1, 6, 0, 0);
    expect_at(2, 0, 0, 0); expect_at(2, 2, 0, 1); expect_at(2, 4, 0, 12); expect_at(2, 6, 0, 0);
    step(1);
    reset = 1'b1;
    set_en = 1'b0;
    step(1);

    // T3: TICKS_PER_SEC=4, en low for 3 clocks after two enabled clocks
    en4 = 1'b1;
    expect_at(5, 8, 0, 0); expect_at(6, 8, 0, 0); expect_at(7, 8, 0, 1); expect_at(11, 8, 0, 2);
    step(2);
    en4 = 1'b0;
    step(3);
    en4 = 1'b1;
    step(6);
    step(2);

    if (sb.size() != 0) begin
      $display("FAIL drain pending=%0d required=0", sb.size());
      total += sb.size();
      bad   += sb.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
